// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths and FSM state encoding for the data-memory responder
// Contents: ADDR_W/DATA_W/BE_W word-interface widths, state_t (IDLE, WAIT, RESP).
package mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/bytemem.sv
// rtl/bytemem.sv - DEPTH x 32-bit storage, byte-enabled synchronous write, registered read
// Ports:
//   clk    : write and read-register clock
//   we     : write strobe, bytes selected by be
//   re     : read strobe, loads rdata with the addressed word
//   be     : byte enables, bit i covers wdata[8i+7:8i]
//   addr   : word address, $clog2(DEPTH) bits
//   wdata  : write data
//   rdata  : registered read data, holds until the next re
module bytemem
    import mem_pkg::*;
#(
    parameter int    DEPTH     = 4096,
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [BE_W-1:0]          be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage has no reset; its contents survive the responder's reset.

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with fixed wait states
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_write             : 1 = store, 0 = load
//   req_addr, req_wdata   : word address, store data
//   req_be                : byte enables (all-zero is an error)
//   rsp_valid/rsp_ready   : response handshake (valid only in RESP)
//   rsp_rdata             : load data, 0 for stores and errors
//   rsp_err               : request rejected, storage untouched
module dmem_responder
    import mem_pkg::*;
#(
    parameter int    WAIT_STATES = 2,
    parameter int    DEPTH       = 4096,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int MEM_AW = $clog2(DEPTH);

    state_t            state;
    logic [3:0]        cnt;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    logic              accept;
    logic              acc_now;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              acc_err;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // req_ready is its own register so it stays low under reset and rises
    // on the first edge after release, while state already reads IDLE.
    assign accept = (state == IDLE) && req_valid && req_ready_q;

    // With zero wait states the access happens on the accepting edge and
    // must use the live request; otherwise it uses the captured fields.
    always_comb begin
        acc_write = write_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
    end

    assign acc_now = (accept && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (cnt == 4'd1));
    assign acc_err = (acc_be == '0) || ({1'b0, acc_addr} >= 13'(DEPTH));
    assign mem_we  = acc_now && acc_write && !acc_err;
    assign mem_re  = acc_now && !acc_write && !acc_err;

    bytemem #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .be    (acc_be),
        .addr  (acc_addr[MEM_AW-1:0]),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        write_q     <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        be_q        <= req_be;
                        cnt         <= 4'(WAIT_STATES);
                        req_ready_q <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= acc_err;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= acc_err;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    // The memory read register only reloads on a load access, so it is
    // masked to zero for stores, errors and outside RESP.
    assign rsp_rdata = (rsp_valid_q && !rsp_err_q && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_ready = 1'b1;

    logic        rdy0, vld0, er0, rdy1, vld1, er1;
    logic [31:0] rd0, rd1;
    logic        rdy, vld, er;
    logic [31:0] rd;

    int n_checks = 0;
    int n_err = 0;
    logic [31:0] got_rd;
    logic        got_err;
    int          got_lat;
    int          pulses;
    logic        rdy_after_hs;
    logic [31:0] first_rd;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_STATES(2), .DEPTH(2048), .INIT_FILE("")) u_ws2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && !sel), .req_ready(rdy0),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld0), .rsp_ready(rsp_ready),
        .rsp_rdata(rd0), .rsp_err(er0)
    );

    dmem_responder #(.WAIT_STATES(0), .DEPTH(4096), .INIT_FILE("")) u_ws0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel), .req_ready(rdy1),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld1), .rsp_ready(rsp_ready),
        .rsp_rdata(rd1), .rsp_err(er1)
    );

    assign rdy = sel ? rdy1 : rdy0;
    assign vld = sel ? vld1 : vld0;
    assign rd  = sel ? rd1  : rd0;
    assign er  = sel ? er1  : er0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request, scramble the inputs after acceptance, and return
    // once rsp_valid is seen; got_lat counts cycles from the accepting edge.
    task automatic issue(input string tag, input logic w, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = b;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d; req_be = ~b;
        got_lat = 1;
        while (!vld && got_lat < 40) begin
            @(posedge clk); #1;
            got_lat++;
        end
        if (got_lat >= 40) check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
        got_rd  = rd;
        got_err = er;
    endtask

    task automatic finish_rsp();
        @(posedge clk); #1;
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready0", 32'(rdy0), 32'd0);
        check("rst_valid0", 32'(vld0), 32'd0);
        check("rst_rdata0", rd0, 32'd0);
        check("rst_err0",   32'(er0), 32'd0);
        check("rst_ready1", 32'(rdy1), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", 32'(rdy0), 32'd1);

        // full-word store then load
        issue("st010", 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
        check("st010_lat", 32'(got_lat), 32'd3);
        check("st010_err", 32'(got_err), 32'd0);
        check("st010_rdata", got_rd, 32'd0);
        finish_rsp();
        issue("ld010", 1'b0, 12'h010, 32'h0, 4'hF);
        check("ld010_lat", 32'(got_lat), 32'd3);
        check("ld010_rdata", got_rd, 32'hDEADBEEF);
        check("ld010_err", 32'(got_err), 32'd0);
        finish_rsp();

        // partial store on byte 1 only
        issue("st040", 1'b1, 12'h040, 32'h11223344, 4'hF);
        finish_rsp();
        issue("st040_be2", 1'b1, 12'h040, 32'h0000AA00, 4'h2);
        finish_rsp();
        issue("ld040", 1'b0, 12'h040, 32'h0, 4'h1);
        check("ld040_rdata", got_rd, 32'h1122AA44);
        finish_rsp();

        // error cases: be==0 store, out-of-range load
        issue("st020", 1'b1, 12'h020, 32'h55667788, 4'hF);
        finish_rsp();
        issue("st020_be0", 1'b1, 12'h020, 32'hFFFFFFFF, 4'h0);
        check("be0_err", 32'(got_err), 32'd1);
        check("be0_rdata", got_rd, 32'd0);
        check("be0_lat", 32'(got_lat), 32'd3);
        finish_rsp();
        check("err_cleared", 32'(er0), 32'd0);
        issue("ld800", 1'b0, 12'h800, 32'h0, 4'hF);
        check("oob_err", 32'(got_err), 32'd1);
        check("oob_rdata", got_rd, 32'd0);
        check("oob_lat", 32'(got_lat), 32'd3);
        finish_rsp();
        issue("ld020", 1'b0, 12'h020, 32'h0, 4'hF);
        check("ld020_unchanged", got_rd, 32'h55667788);
        check("ld020_err", 32'(got_err), 32'd0);
        finish_rsp();

        // response backpressure
        rsp_ready = 1'b0;
        issue("hold", 1'b0, 12'h010, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold_valid_%0d", i), 32'(vld0), 32'd1);
            check($sformatf("hold_rdata_%0d", i), rd0, 32'hDEADBEEF);
            check($sformatf("hold_ready_%0d", i), 32'(rdy0), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_valid_drop", 32'(vld0), 32'd0);
        check("hold_ready_back", 32'(rdy0), 32'd1);

        // reset during WAIT of a store discards it
        issue("st030", 1'b1, 12'h030, 32'hCAFEF00D, 4'hF);
        finish_rsp();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h030;
        req_wdata = 32'h12345678; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_wait_was_busy", 32'(rdy0), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("rstw_valid", 32'(vld0), 32'd0);
        check("rstw_rdata", rd0, 32'd0);
        check("rstw_err",   32'(er0), 32'd0);
        check("rstw_ready", 32'(rdy0), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstw_ready_release", 32'(rdy0), 32'd1);
        issue("ld030", 1'b0, 12'h030, 32'h0, 4'hF);
        check("ld030_prior", got_rd, 32'hCAFEF00D);
        finish_rsp();

        // zero wait states
        sel = 1'b1;
        issue("ws0_st", 1'b1, 12'h100, 32'hA5A5A5A5, 4'hF);
        check("ws0_st_lat", 32'(got_lat), 32'd1);
        finish_rsp();
        issue("ws0_ld", 1'b0, 12'h100, 32'h0, 4'hF);
        check("ws0_ld_lat", 32'(got_lat), 32'd1);
        check("ws0_ld_rdata", got_rd, 32'hA5A5A5A5);
        finish_rsp();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h100; req_be = 4'hF;
        pulses = 0;
        rdy_after_hs = 1'b0;
        first_rd = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (vld1) pulses++;
            if (i == 1) first_rd = rd1;
            if (i == 2) rdy_after_hs = rdy1;
        end
        req_valid = 1'b0;
        check("ws0_b2b_pulses", 32'(pulses), 32'd4);
        check("ws0_b2b_rdata", first_rd, 32'hA5A5A5A5);
        check("ws0_ready_after_hs", 32'(rdy_after_hs), 32'd1);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
